// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: synchronizes raw sources, detects edges, keeps a
// saturating per-source edge counter, and runs a per-source
// IDLE -> PEND -> INFL handshake with the core's claim/complete strobes.
// Source 0 is reserved and never requests.
module plic_gateway #(
  parameter int IRQ_NUM   = 32,
  parameter int IRQ_WIDTH = 5,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IRQ_NUM-1:0]   irq_i,
  input  logic [IRQ_NUM-1:0]   tm_i,
  input  logic                 en_i,
  input  logic                 clam_i,
  input  logic [IRQ_WIDTH-1:0] clam_id_i,
  input  logic                 comp_i,
  input  logic [IRQ_WIDTH-1:0] comp_id_i,
  output logic [IRQ_NUM-1:0]   req_o,
  output logic [IRQ_NUM-1:0]   busy_o,
  output logic [IRQ_NUM-1:0]   ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_INFL = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

  logic [IRQ_NUM-1:0]   sync1_q;
  logic [IRQ_NUM-1:0]   sync2_q;
  logic [IRQ_NUM-1:0]   sdly_q;
  logic [IRQ_NUM-1:0]   rise;
  logic [IRQ_NUM-1:0]   fwd;
  state_e               st_q  [IRQ_NUM];
  state_e               st_d  [IRQ_NUM];
  logic [CNT_WIDTH-1:0] cnt_q [IRQ_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [IRQ_NUM];
  logic [IRQ_NUM-1:0]   ovf_q;
  logic [IRQ_NUM-1:0]   ovf_d;
  logic [IRQ_NUM-1:0]   req_q;
  logic [IRQ_NUM-1:0]   busy_q;

  // Next-state for every source: forward decision, handshake FSM, edge counter.
  always_comb begin
    logic [CNT_WIDTH:0] sum;
    sum  = '0;
    rise = sync2_q & ~sdly_q;
    fwd  = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
    end
    for (int i = 1; i < IRQ_NUM; i++) begin
      // A pending edge count or a fresh rise forwards in edge mode;
      // the synchronized level forwards in level mode.
      fwd[i] = (st_q[i] == ST_IDLE) & en_i &
               (tm_i[i] ? ((cnt_q[i] != '0) | rise[i]) : sync2_q[i]);

      case (st_q[i])
        ST_IDLE: if (fwd[i]) st_d[i] = ST_PEND;
        ST_PEND: if (clam_i && (clam_id_i == IRQ_WIDTH'(i))) st_d[i] = ST_INFL;
        ST_INFL: if (comp_i && (comp_id_i == IRQ_WIDTH'(i))) st_d[i] = ST_IDLE;
        default: st_d[i] = ST_IDLE;
      endcase

      // Edges are counted in every state; the forward consumes one count.
      // fwd in edge mode implies cnt!=0 or rise, so the sum cannot underflow.
      if (!tm_i[i]) begin
        cnt_d[i] = '0;
      end else begin
        sum = {1'b0, cnt_q[i]} + {{CNT_WIDTH{1'b0}}, rise[i]}
                               - {{CNT_WIDTH{1'b0}}, fwd[i]};
        if (sum > CNT_MAX) begin
          cnt_d[i] = CNT_MAX[CNT_WIDTH-1:0];
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = sum[CNT_WIDTH-1:0];
        end
      end
    end
    // Reserved source 0 never leaves IDLE and never counts.
    st_d[0]  = ST_IDLE;
    cnt_d[0] = '0;
    ovf_d[0] = 1'b0;
  end

  // Synchronizers, per-source state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sdly_q  <= '0;
      ovf_q   <= '0;
      req_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < IRQ_NUM; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      sdly_q  <= sync2_q;
      ovf_q   <= ovf_d;
      for (int i = 0; i < IRQ_NUM; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        req_q[i]  <= (st_d[i] == ST_PEND);
        busy_q[i] <= (st_d[i] == ST_INFL);
      end
    end
  end

  assign req_o  = req_q;
  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: level/edge flows, counter saturation,
// reserved source 0, ignored strobes, simultaneous claim/complete, reset.
module tb_plic_gateway;

  localparam int IRQ_NUM   = 32;
  localparam int IRQ_WIDTH = 5;
  localparam int CNT_WIDTH = 4;

  logic                 clk;
  logic                 rst;
  logic [IRQ_NUM-1:0]   irq;
  logic [IRQ_NUM-1:0]   tm;
  logic                 en;
  logic                 clam;
  logic [IRQ_WIDTH-1:0] clam_id;
  logic                 comp;
  logic [IRQ_WIDTH-1:0] comp_id;
  logic [IRQ_NUM-1:0]   req;
  logic [IRQ_NUM-1:0]   busy;
  logic [IRQ_NUM-1:0]   ovf;

  int n_checks = 0;
  int n_fail   = 0;

  plic_gateway #(
    .IRQ_NUM  (IRQ_NUM),
    .IRQ_WIDTH(IRQ_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .irq_i    (irq),
    .tm_i     (tm),
    .en_i     (en),
    .clam_i   (clam),
    .clam_id_i(clam_id),
    .comp_i   (comp),
    .comp_id_i(comp_id),
    .req_o    (req),
    .busy_o   (busy),
    .ovf_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulses(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      irq[idx] = 1'b1; tick(); tick();
      irq[idx] = 1'b0; tick(); tick();
    end
    repeat (3) tick();
  endtask

  task automatic claim(input int id);
    clam = 1'b1; clam_id = IRQ_WIDTH'(id);
    tick();
    clam = 1'b0;
  endtask

  task automatic complete(input int id);
    comp = 1'b1; comp_id = IRQ_WIDTH'(id);
    tick();
    comp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; tm = '0; en = 1'b0;
    clam = 1'b0; clam_id = '0; comp = 1'b0; comp_id = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_req",  {32'd0, req},  64'h0);
    check("reset_busy", {32'd0, busy}, 64'h0);
    check("reset_ovf",  {32'd0, ovf},  64'h0);

    // Level source 3: two-edge latency, claim, complete with line still high.
    en = 1'b1; irq[3] = 1'b1;
    tick(); check("lvl_edge0_req", {32'd0, req}, 64'h0);
    tick(); check("lvl_edge1_req", {32'd0, req}, 64'h0);
    tick(); check("lvl_edge2_req", {32'd0, req}, 64'h8);
    claim(3);
    check("lvl_claim_req",  {32'd0, req},  64'h0);
    check("lvl_claim_busy", {32'd0, busy}, 64'h8);
    complete(3);
    check("lvl_comp_busy", {32'd0, busy}, 64'h0);
    check("lvl_comp_req",  {32'd0, req},  64'h0);
    tick(); check("lvl_refwd_req", {32'd0, req}, 64'h8);
    do_reset();

    // Ignored strobes on source 4, then simultaneous claim/complete.
    claim(4);
    check("ign_claim_idle_busy", {32'd0, busy}, 64'h0);
    check("ign_claim_idle_req",  {32'd0, req},  64'h0);
    irq[3] = 1'b1; irq[4] = 1'b1;
    repeat (3) tick();
    check("two_pend_req", {32'd0, req}, 64'h18);
    complete(4);
    check("ign_comp_pend_req",  {32'd0, req},  64'h18);
    check("ign_comp_pend_busy", {32'd0, busy}, 64'h0);
    claim(3);
    check("claim3_busy", {32'd0, busy}, 64'h8);
    clam = 1'b1; clam_id = 5'd4; comp = 1'b1; comp_id = 5'd3;
    tick();
    clam = 1'b0; comp = 1'b0;
    check("simul_busy", {32'd0, busy}, 64'h10);
    check("simul_req",  {32'd0, req},  64'h0);
    irq = '0;
    do_reset();

    // Reserved source 0.
    irq[0] = 1'b1;
    repeat (3) tick();
    check("src0_req", {32'd0, req}, 64'h0);
    claim(0);
    complete(0);
    check("src0_busy", {32'd0, busy}, 64'h0);
    check("src0_req2", {32'd0, req},  64'h0);
    irq[0] = 1'b0;
    do_reset();

    // Edge source 5: edges while in flight are banked, completion re-forwards.
    tm[5] = 1'b1; irq[5] = 1'b1;
    repeat (3) tick();
    check("edge5_req", {32'd0, req}, 64'h20);
    check("edge5_cnt0", {60'd0, dut.cnt_q[5]}, 64'd0);
    irq[5] = 1'b0;
    claim(5);
    check("edge5_busy", {32'd0, busy}, 64'h20);
    pulses(5, 3);
    check("edge5_cnt3", {60'd0, dut.cnt_q[5]}, 64'd3);
    complete(5);
    check("edge5_comp_busy", {32'd0, busy}, 64'h0);
    tick();
    check("edge5_refwd_req", {32'd0, req}, 64'h20);
    check("edge5_cnt2", {60'd0, dut.cnt_q[5]}, 64'd2);
    tm = '0;
    do_reset();

    // Edge source 7: saturation with forwarding disabled.
    tm[7] = 1'b1; en = 1'b0;
    pulses(7, 16);
    check("sat_cnt15", {60'd0, dut.cnt_q[7]}, 64'd15);
    check("sat_ovf",   {32'd0, ovf}, 64'h80);
    check("sat_req0",  {32'd0, req}, 64'h0);
    en = 1'b1;
    tick();
    check("sat_en_req",  {32'd0, req}, 64'h80);
    check("sat_en_cnt",  {60'd0, dut.cnt_q[7]}, 64'd14);
    check("sat_ovf_hold", {32'd0, ovf}, 64'h80);

    // Source 2 in flight with 5 banked edges, then reset mid-operation.
    tm[2] = 1'b1; irq[2] = 1'b1;
    repeat (3) tick();
    irq[2] = 1'b0;
    claim(2);
    pulses(2, 5);
    check("rst_pre_busy", {32'd0, busy}, 64'h4);
    check("rst_pre_cnt",  {60'd0, dut.cnt_q[2]}, 64'd5);
    do_reset();
    check("rst_req",  {32'd0, req},  64'h0);
    check("rst_busy", {32'd0, busy}, 64'h0);
    check("rst_ovf",  {32'd0, ovf},  64'h0);
    check("rst_cnt",  {60'd0, dut.cnt_q[2]}, 64'd0);
    tick();
    check("rst_post_req", {32'd0, req}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_gateway.md
PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 Parameter IRQ_NUM, default 32, meaning number of sources, index 0 reserved.
REQ-002 Parameter IRQ_WIDTH, default 5, meaning width of source ID, equal to log2(IRQ_NUM).
REQ-003 Parameter CNT_WIDTH, default 4, meaning width of per-source edge pending counter.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 irq_i  input  IRQ_NUM  raw interrupt sources, asynchronous to clk_i.
REQ-007 tm_i  input  IRQ_NUM  trigger mode per source; 1 = edge, 0 = level.
REQ-008 en_i  input  1  global forward enable.
REQ-009 clam_i  input  1  claim strobe from core, one cycle.
REQ-010 clam_id_i  input  IRQ_WIDTH  ID being claimed.
REQ-011 comp_i  input  1  completion strobe, one cycle.
REQ-012 comp_id_i  input  IRQ_WIDTH  ID being completed.
REQ-013 req_o  output  IRQ_NUM  pending request per source to core (registered).
REQ-014 busy_o  output  IRQ_NUM  source claimed, awaiting completion (registered).
REQ-015 ovf_o  output  IRQ_NUM  sticky edge-counter overflow flag (registered).

Function
REQ-016 Each irq_i bit SHALL pass a 2-flop synchronizer; s = second flop output; s_d = s delayed one cycle.
REQ-017 rise[i] SHALL equal s[i] & ~s_d[i].
REQ-018 Each source i >= 1 SHALL run FSM IDLE -> PEND -> INFL -> IDLE; req_o[i] = (state==PEND), busy_o[i] = (state==INFL).
REQ-019 fwd[i] SHALL equal (state==IDLE) & en_i & (tm_i[i] ? (cnt!=0 | rise) : s[i]); fwd moves IDLE -> PEND next edge.
REQ-020 PEND -> INFL SHALL occur when clam_i & clam_id_i==i; claim for a source not in PEND is ignored.
REQ-021 INFL -> IDLE SHALL occur when comp_i & comp_id_i==i; completion for a source not in INFL is ignored.
REQ-022 Level mode: PEND is held until claim even if s[i] deasserts; after completion, if s[i] still high, re-forward from IDLE.
REQ-023 Edge mode: cnt_next = cnt + rise - fwd (fwd only when tm_i=1), computed in CNT_WIDTH+1 bits.
REQ-024 Counter SHALL saturate at 2^CNT_WIDTH-1: rise at max without fwd leaves cnt at max and sets ovf_o[i].
REQ-025 rise and fwd in same cycle SHALL leave cnt unchanged.
REQ-026 Edges SHALL be counted in every state and when en_i=0; cnt is cleared when tm_i[i]=0.
REQ-027 tm_i changes SHALL affect only the next IDLE forward decision; PEND/INFL are not aborted.
REQ-028 ovf_o[i] SHALL clear only on reset.
REQ-029 Source 0: req_o[0], busy_o[0], ovf_o[0] SHALL be constant 0; claim/complete of ID 0 ignored.
REQ-030 Latency: irq_i high before edge 0 SHALL give req_o high after edge 2 (both modes, en_i=1, IDLE).
REQ-031 Simultaneous claim and completion of different IDs SHALL both take effect in the same cycle.

Reset
REQ-032 With rst_i high at a clock edge: synchronizers, s_d, all cnt, ovf_o cleared; all FSMs IDLE; req_o=0, busy_o=0.
REQ-033 Reset mid-operation (PEND or INFL) SHALL discard the request; no completion is required afterward.

Verification
REQ-034 Level src 3, irq_i[3]=1 at edge 0 -> req_o=0x8 after edge 2; claim ID 3 -> req_o=0, busy_o=0x8; comp ID 3 with irq high -> req_o=0x8 two edges later.
REQ-035 Edge src 5, 3 pulses (2 cycles high/low) while in INFL -> cnt=3; comp ID 5 -> PEND next edge, cnt=2.
REQ-036 Edge src 7, 16 pulses with en_i=0 -> cnt=15, ovf_o=0x80; en_i=1 -> req_o[7]=1, cnt=14.
REQ-037 irq_i[0]=1, claim/comp ID 0 -> req_o[0], busy_o[0] stay 0.
REQ-038 Claim ID 4 while src 4 IDLE; comp ID 4 while PEND -> no state change.
REQ-039 rst_i pulse with src 2 in INFL and cnt=5 -> next cycle req_o=0, busy_o=0, ovf_o=0, cnt=0.
